decode: RTL
===========

# decode

Second pipeline stage of the in-order RV32I core. It sits directly downstream of fetch: each cycle it takes the raw instruction word and its address and decodes fields and the sign-extended immediate. It reads both source operands from the 32×32 integer register file it owns, whose write port is driven by writeback. Results are registered into the decode→execute pipeline register, which jump flushes and the post-jump bubble clear.

## Interface
- No parameters (XLEN fixed at 32, 32 architectural registers).
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_addr_in  in  32  instruction address from fetch's pipeline register
- instr_dat_in  in  32  raw instruction word from fetch (instruction memory data)
- bubble_in  in  1  fetch's stall_out; 1 = current instr_dat_in is not a real instruction
- flush_in  in  1  writeback jmp_tk; 1 = squash the instruction entering this stage
- wb_en  in  1  register-file write enable from writeback
- wb_rd  in  5  register-file write index
- wb_dat  in  32  register-file write data
- d_valid  out  1  output register holds a real instruction
- d_pc  out  32  instruction address
- d_opcode  out  7  instr[6:0]
- d_rd, d_rs1, d_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- d_funct3  out  3  instr[14:12]
- d_funct7b5  out  1  instr[30]
- d_rs1_dat, d_rs2_dat  out  32 each  source operand values
- d_imm  out  32  sign-extended immediate per instruction format
- d_illegal  out  1  opcode not a supported RV32I major opcode

## Operation
- Register file: 32 entries × 32 bits. x0 reads 0 always; writes with wb_rd=0 are discarded. Write occurs at the rising edge when wb_en=1.
- Read bypass: if wb_en=1, wb_rd≠0 and wb_rd equals rs1 (or rs2) of the instruction being decoded, the captured operand is wb_dat, not the stale array value. Both operands bypass independently.
- Immediate by opcode:
  - I (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): sext(instr[31:20]).
  - S (0100011): sext({instr[31:25], instr[11:7]}).
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (LUI 0110111, AUIPC 0010111): {instr[31:12], 12'b0}.
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Everything else: 0.
- Illegal detection:
  - d_illegal=1 when instr[1:0]≠2'b11, or the opcode is outside the set above plus OP 0110011 and MISC-MEM 0001111.
  - An illegal instruction still propagates with d_valid=1; handling is downstream.
- Output register update each rising edge, in priority order:
  - flush_in=1 → d_valid=0, all other outputs 0.
  - else bubble_in=1 → d_valid=0, all other outputs 0.
  - else capture the decoded instruction, d_valid=1.
- No backpressure: the stage accepts a new input every cycle.

## Timing
- Reset (rst_n=0, asynchronous): every output 0, including d_valid=0 and d_illegal=0. All 32 register-file entries are cleared to 0.
- Reset release mid-stream: the first capture happens at the first rising edge with rst_n=1.
- Latency: an instruction presented in cycle N appears on d_* in cycle N+1. Decode is combinational from inputs to the register.
- Register-file write and bypass:
  - A write at edge E is visible through the array to instructions decoded after E.
  - The bypass covers the instruction captured at the same edge E.
- Simultaneous flush_in and bubble_in: result is a bubble; flush has priority, but the outcome is identical.
- Writes from wb_en proceed regardless of flush_in or bubble_in.

## Test plan
- Reset, then rst_n=1; decode 0x00500093 (addi x1,x0,5) at 0x80000000 → next cycle d_valid=1, d_pc=0x80000000, d_rd=1, d_rs1=0, d_imm=0x00000005, d_rs1_dat=0, d_illegal=0.
- Bypass: wb_en=1, wb_rd=2, wb_dat=0xDEADBEEF in the same cycle as 0x002101B3 (add x3,x2,x2) → d_rs1_dat=d_rs2_dat=0xDEADBEEF, d_rd=3. Then decode 0x00010093 (addi x1,x2,0) with wb_en=0 → d_rs1_dat=0xDEADBEEF from the array.
- x0 protection: wb_en=1, wb_rd=0, wb_dat=0x12345678, then decode 0x00000093 → d_rs1_dat=0.
- Immediates: 0xFE000CE3 (beq x0,x0,-8) → d_imm=0xFFFFFFF8. 0x123452B7 (lui x5) → d_imm=0x12345000. 0xFE112E23 (sw x1,-4(x2)) → d_imm=0xFFFFFFFC.
- Flush/bubble: flush_in=1 with a valid instruction → next cycle d_valid=0, all outputs 0. bubble_in=1 the following cycle → d_valid=0. Normal input after that → d_valid=1.
- Illegal and async reset: 0x00000000 → d_valid=1, d_illegal=1. Then assert rst_n=0 between edges → all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/decode.sv
// Decode stage of the in-order RV32I core: field extraction, immediate generation,
// integer register file with writeback bypass, and the decode-to-execute register.
module decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_addr_in,
    input  logic [31:0] instr_dat_in,
    input  logic        bubble_in,
    input  logic        flush_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_dat,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [6:0]  d_opcode,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [2:0]  d_funct3,
    output logic        d_funct7b5,
    output logic [31:0] d_rs1_dat,
    output logic [31:0] d_rs2_dat,
    output logic [31:0] d_imm,
    output logic        d_illegal
);

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] rs1_dat, rs2_dat;

    assign instr  = instr_dat_in;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    always_comb begin
        imm     = 32'h0;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD, OP_OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'h000};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_OP, OP_MISC_MEM:
                imm = 32'h0;
            default:
                illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end

    // The write landing at this edge must be seen by the instruction captured at the same edge.
    always_comb begin
        rs1_dat = 32'h0;
        rs2_dat = 32'h0;
        if (rs1 != 5'd0) begin
            rs1_dat = (wb_en && wb_rd == rs1) ? wb_dat : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_dat = (wb_en && wb_rd == rs2) ? wb_dat : regs[rs2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid    <= 1'b0;
            d_pc       <= 32'h0;
            d_opcode   <= 7'h0;
            d_rd       <= 5'h0;
            d_rs1      <= 5'h0;
            d_rs2      <= 5'h0;
            d_funct3   <= 3'h0;
            d_funct7b5 <= 1'b0;
            d_rs1_dat  <= 32'h0;
            d_rs2_dat  <= 32'h0;
            d_imm      <= 32'h0;
            d_illegal  <= 1'b0;
        end else if (flush_in || bubble_in) begin
            d_valid    <= 1'b0;
            d_pc       <= 32'h0;
            d_opcode   <= 7'h0;
            d_rd       <= 5'h0;
            d_rs1      <= 5'h0;
            d_rs2      <= 5'h0;
            d_funct3   <= 3'h0;
            d_funct7b5 <= 1'b0;
            d_rs1_dat  <= 32'h0;
            d_rs2_dat  <= 32'h0;
            d_imm      <= 32'h0;
            d_illegal  <= 1'b0;
        end else begin
            d_valid    <= 1'b1;
            d_pc       <= instr_addr_in;
            d_opcode   <= opcode;
            d_rd       <= rd;
            d_rs1      <= rs1;
            d_rs2      <= rs2;
            d_funct3   <= instr[14:12];
            d_funct7b5 <= instr[30];
            d_rs1_dat  <= rs1_dat;
            d_rs2_dat  <= rs2_dat;
            d_imm      <= imm;
            d_illegal  <= illegal;
        end
    end

endmodule
